// File: rtl/ifq_if.sv
// Instruction-cache request/response bus of the fetch queue.
// master = fetch queue side, slave = cache side.
interface ifq_if;
    logic        ifq_cache_rd_en;
    logic [31:0] ifq_cache_addr;
    logic [31:0] cache_data;
    logic        cache_valid;

    modport master (
        output ifq_cache_rd_en,
        output ifq_cache_addr,
        input  cache_data,
        input  cache_valid
    );

    modport slave (
        input  ifq_cache_rd_en,
        input  ifq_cache_addr,
        output cache_data,
        output cache_valid
    );
endinterface

// File: rtl/ifq.sv
// Instruction fetch queue: 4-entry show-ahead FIFO of {pc+4, instr}
// fed by a one-outstanding-request fetch FSM with redirect flush.
module ifq (
    input  logic        clock,
    input  logic        reset,
    input  logic        Dispatch_ren,
    input  logic        Dispatch_jmp,
    input  logic [32:0] Dispatch_jmp_addr,
    output logic [32:0] ifetch_pc_4,
    output logic [32:0] ifetch_intruction,
    output logic        ifetch_empty,
    ifq_if.master       cache
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] pc_q [4];
    logic [31:0] instr_q [4];
    logic [1:0]  rptr;
    logic [1:0]  wptr;
    logic [2:0]  count;
    logic        req;
    logic        wr;
    logic        rd;
    logic        unused_addr_msb;

    assign unused_addr_msb = Dispatch_jmp_addr[32];

    // Request gated by reset so the bus is quiet while reset is held.
    assign req = reset && (state == IDLE) && (count != 3'd4)
                 && !Dispatch_jmp;
    assign wr  = (state == WAIT) && cache.cache_valid && !Dispatch_jmp;
    assign rd  = Dispatch_ren && (count != 3'd0) && !Dispatch_jmp;

    assign cache.ifq_cache_rd_en = req;
    assign cache.ifq_cache_addr  = req ? pc : 32'd0;

    assign ifetch_empty      = (count == 3'd0);
    assign ifetch_pc_4       = ifetch_empty ? 33'd0 : {1'b0, pc_q[rptr]};
    assign ifetch_intruction = ifetch_empty ? 33'd0 : {1'b0, instr_q[rptr]};

    // Fetch FSM next state; a redirect with a response in flight
    // must swallow that response in DISCARD.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) state_nxt = WAIT;
            end
            WAIT: begin
                if (Dispatch_jmp)
                    state_nxt = cache.cache_valid ? IDLE : DISCARD;
                else if (cache.cache_valid)
                    state_nxt = IDLE;
            end
            DISCARD: begin
                if (cache.cache_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Fetch PC and address of the outstanding request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc     <= 32'd0;
            req_pc <= 32'd0;
        end else if (Dispatch_jmp) begin
            pc <= Dispatch_jmp_addr[31:0];
        end else if (req) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
        end
    end

    // Queue storage, pointers and occupancy; redirect empties it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr  <= 2'd0;
            wptr  <= 2'd0;
            count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                pc_q[i]    <= 32'd0;
                instr_q[i] <= 32'd0;
            end
        end else if (Dispatch_jmp) begin
            rptr  <= 2'd0;
            wptr  <= 2'd0;
            count <= 3'd0;
        end else begin
            if (wr) begin
                pc_q[wptr]    <= req_pc + 32'd4;
                instr_q[wptr] <= cache.cache_data;
                wptr          <= wptr + 2'd1;
            end
            if (rd) rptr <= rptr + 2'd1;
            unique case ({wr, rd})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ifq.sv
// Directed bench for the instruction fetch queue.
// Cache responses are driven by hand, one cycle per step.
module tb_ifq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        Dispatch_ren = 1'b0;
    logic        Dispatch_jmp = 1'b0;
    logic [32:0] Dispatch_jmp_addr = 33'd0;
    logic [32:0] ifetch_pc_4;
    logic [32:0] ifetch_intruction;
    logic        ifetch_empty;

    int checks = 0;
    int failures = 0;

    ifq_if cif ();

    ifq dut (
        .clock             (clock),
        .reset             (reset),
        .Dispatch_ren      (Dispatch_ren),
        .Dispatch_jmp      (Dispatch_jmp),
        .Dispatch_jmp_addr (Dispatch_jmp_addr),
        .ifetch_pc_4       (ifetch_pc_4),
        .ifetch_intruction (ifetch_intruction),
        .ifetch_empty      (ifetch_empty),
        .cache             (cif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic resp(input logic [31:0] d);
        cif.cache_valid = 1'b1;
        cif.cache_data  = d;
        tick();
        cif.cache_valid = 1'b0;
        cif.cache_data  = 32'd0;
        #1;
    endtask

    task automatic fetch(input logic [31:0] d);
        tick();
        resp(d);
    endtask

    initial begin
        cif.cache_valid = 1'b0;
        cif.cache_data  = 32'd0;

        // reset values
        #12;
        check("rst_empty", ifetch_empty, 1);
        check("rst_pc4", ifetch_pc_4, 0);
        check("rst_instr", ifetch_intruction, 0);
        check("rst_rden", cif.ifq_cache_rd_en, 0);
        check("rst_addr", cif.ifq_cache_addr, 0);

        // basic fetch
        tick();
        reset = 1'b1;
        #1;
        check("f0_rden", cif.ifq_cache_rd_en, 1);
        check("f0_addr", cif.ifq_cache_addr, 32'h0);
        tick();
        cif.cache_valid = 1'b1;
        cif.cache_data  = 32'h1111_1111;
        #1;
        check("wait_rden", cif.ifq_cache_rd_en, 0);
        tick();
        cif.cache_valid = 1'b0;
        #1;
        check("f0_empty", ifetch_empty, 0);
        check("f0_pc4", ifetch_pc_4, 33'h4);
        check("f0_instr", ifetch_intruction, 33'h1111_1111);
        check("f1_rden", cif.ifq_cache_rd_en, 1);
        check("f1_addr", cif.ifq_cache_addr, 32'h4);

        // fill to 4
        fetch(32'h2222_2222);
        fetch(32'h3333_3333);
        fetch(32'h4444_4444);
        check("full_cnt", dut.count, 4);
        check("full_rden", cif.ifq_cache_rd_en, 0);
        tick();
        check("full_rden2", cif.ifq_cache_rd_en, 0);
        Dispatch_ren = 1'b1;
        #1;
        tick();
        Dispatch_ren = 1'b0;
        #1;
        check("pop_cnt", dut.count, 3);
        check("pop_pc4", ifetch_pc_4, 33'h8);
        check("pop_instr", ifetch_intruction, 33'h2222_2222);
        check("pop_rden", cif.ifq_cache_rd_en, 1);
        check("pop_addr", cif.ifq_cache_addr, 32'h10);

        // jump flush with 3 entries, ren ignored
        Dispatch_jmp      = 1'b1;
        Dispatch_jmp_addr = 33'h1_0000_0100;
        Dispatch_ren      = 1'b1;
        #1;
        check("jmp_norq", cif.ifq_cache_rd_en, 0);
        tick();
        Dispatch_jmp      = 1'b0;
        Dispatch_jmp_addr = 33'd0;
        Dispatch_ren      = 1'b0;
        #1;
        check("jmp_empty", ifetch_empty, 1);
        check("jmp_cnt", dut.count, 0);
        check("jmp_rptr", dut.rptr, 0);
        check("jmp_rden", cif.ifq_cache_rd_en, 1);
        check("jmp_addr", cif.ifq_cache_addr, 32'h100);

        // jump while a request is pending
        fetch(32'h5555_5555);
        check("j1_pc4", ifetch_pc_4, 33'h104);
        Dispatch_jmp      = 1'b1;
        Dispatch_jmp_addr = 33'h8;
        tick();
        Dispatch_jmp = 1'b0;
        #1;
        check("j8_addr", cif.ifq_cache_addr, 32'h8);
        tick();
        Dispatch_jmp      = 1'b1;
        Dispatch_jmp_addr = 33'h200;
        #1;
        check("jw_rden", cif.ifq_cache_rd_en, 0);
        tick();
        Dispatch_jmp = 1'b0;
        #1;
        check("disc_rden", cif.ifq_cache_rd_en, 0);
        tick();
        check("disc_rden2", cif.ifq_cache_rd_en, 0);
        resp(32'hDEAD_BEEF);
        check("disc_empty", ifetch_empty, 1);
        check("disc_cnt", dut.count, 0);
        check("disc_rden3", cif.ifq_cache_rd_en, 1);
        check("disc_addr", cif.ifq_cache_addr, 32'h200);

        // simultaneous write and read
        fetch(32'h0000_A001);
        fetch(32'h0000_A002);
        tick();
        cif.cache_valid = 1'b1;
        cif.cache_data  = 32'h0000_A003;
        Dispatch_ren    = 1'b1;
        tick();
        cif.cache_valid = 1'b0;
        Dispatch_ren    = 1'b0;
        #1;
        check("sim_cnt", dut.count, 2);
        check("sim_pc4", ifetch_pc_4, 33'h208);
        check("sim_instr", ifetch_intruction, 33'h0000_A002);
        check("sim_wptr", dut.wptr, 3);
        check("sim_rptr", dut.rptr, 1);

        // drain, then read on empty
        Dispatch_ren = 1'b1;
        tick();
        check("dr_pc4", ifetch_pc_4, 33'h20C);
        check("dr_instr", ifetch_intruction, 33'h0000_A003);
        tick();
        check("dr_empty", ifetch_empty, 1);
        tick();
        Dispatch_ren = 1'b0;
        #1;
        check("uf_cnt", dut.count, 0);
        check("uf_rptr", dut.rptr, 3);
        check("uf_empty", ifetch_empty, 1);
        resp(32'h0000_A004);
        check("wrap_pc4", ifetch_pc_4, 33'h210);
        check("wrap_instr", ifetch_intruction, 33'h0000_A004);
        check("wrap_wptr", dut.wptr, 0);
        check("wrap_cnt", dut.count, 1);

        // async reset in WAIT
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("ar_empty", ifetch_empty, 1);
        check("ar_pc4", ifetch_pc_4, 0);
        check("ar_instr", ifetch_intruction, 0);
        check("ar_rden", cif.ifq_cache_rd_en, 0);
        check("ar_addr", cif.ifq_cache_addr, 0);
        check("ar_cnt", dut.count, 0);
        tick();
        reset           = 1'b1;
        cif.cache_valid = 1'b1;
        cif.cache_data  = 32'h0000_0BAD;
        #1;
        check("rel_rden", cif.ifq_cache_rd_en, 1);
        check("rel_addr", cif.ifq_cache_addr, 32'h0);
        tick();
        cif.cache_valid = 1'b0;
        #1;
        check("rel_ign", ifetch_empty, 1);
        resp(32'h0000_0077);
        check("rel_pc4", ifetch_pc_4, 33'h4);
        check("rel_instr", ifetch_intruction, 33'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
